fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the control decoder. Holds the program counter and issues one instruction-memory read at a time. Registers each returned instruction word and presents it, with its PC, to decode/execute. Computes the next PC from the `pcsrc` selection returned when that instruction is consumed. The block is strictly single-outstanding: it fetches, holds, resolves, then fetches again, so it needs no flush logic.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` in 1: sole clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` out 1: instruction-memory read request.
- `req_addr` out 32: word address of the request, equal to the current PC.
- `req_ready` in 1: memory accepts the request this cycle.
- `resp_valid` in 1: read data is valid this cycle.
- `resp_data` in 32: instruction word.
- `instr_valid` out 1: `instr` and `instr_pc` hold a fetched instruction.
- `instr` out 32: instruction word; bits [6:0], [14:12] and [31:25] feed the decoder.
- `instr_pc` out 32: PC of `instr`.
- `instr_ready` in 1: downstream consumes `instr` this cycle.
- `pcsrc` in 2: next-PC select, sampled at consume time. Encoding:
  - 00: PC+4.
  - 01: PC+imm when `pc_take`=1.
  - 11: (rs1+imm) with bit 0 cleared.
  - 10: treated as 00.
- `pc_take` in 1: redirect is taken. Asserted for a taken branch or for `jal`; used only when `pcsrc`=01.
- `imm` in 32: sign-extended immediate of the consumed instruction.
- `rs1_data` in 32: rs1 value of the consumed instruction.
- `misalign` out 1: sticky flag; set when a computed target has bits [1:0] ≠ 0.
- `retired` out 32: count of consumed instructions.

## Operation
- The state machine has four states: `S_REQ`, `S_WAIT`, `S_HOLD`, `S_HALT`.
- **`S_REQ`:**
  - `req_valid`=1 and `req_addr`=`pc`.
  - On `req_ready`=1, go to `S_WAIT`.
- **`S_WAIT`:**
  - `req_valid`=0.
  - On `resp_valid`=1, latch `instr`←`resp_data` and `instr_pc`←`pc`, then go to `S_HOLD`.
- **`S_HOLD`:**
  - `instr_valid`=1.
  - On `instr_ready`=1:
    - `retired` increments by 1, wrapping at 2^32.
    - The next PC is computed as:
      - `pcsrc`=01 and `pc_take`=1: `pc`+`imm`.
      - `pcsrc`=11: (`rs1_data`+`imm`) & ~1.
      - Otherwise: `pc`+4.
    - All additions are 32-bit modulo; overflow is discarded and no flag is raised.
    - If next[1:0]=00, then `pc`←next and go to `S_REQ`.
    - Otherwise, set `misalign`, leave `pc` unchanged, and go to `S_HALT`.
- **`S_HALT`:** all outputs hold, `req_valid`=0 and `instr_valid`=0. The state is left only by `rst`.
- **Stray responses:** `resp_valid` outside `S_WAIT` is ignored. This includes a response that arrives after a reset that aborted an outstanding request.
- **`instr_ready` outside `S_HOLD`:** ignored; no count and no PC change.

## Timing
- **Reset values, in the cycle after `rst` is sampled high:**
  - State `S_REQ`.
  - `pc`=`RESET_PC`.
  - `req_valid`=1 and `req_addr`=`RESET_PC`.
  - `instr_valid`=0, `instr`=0 and `instr_pc`=0.
  - `misalign`=0 and `retired`=0.
- **`req_valid` is not combinational on inputs:** it is a decode of the registered state only.
- **`rst` has priority over every other input in every state.** This includes a reset asserted in the same cycle as `req_ready`, `resp_valid` or `instr_ready`.
- **Request and response timing:**
  - A request accepted in cycle t moves the state to `S_WAIT` in t+1.
  - The earliest counted response is in t+1.
  - `resp_valid` in the acceptance cycle t itself is ignored.
- **Response to output:** a response in cycle r gives `instr_valid`=1 from r+1.
- **Consume to next request:** a consume in cycle c gives `req_valid`=1 for the new PC in c+1.
- **Throughput:**
  - Minimum loop is 3 cycles per instruction when `req_ready`, `resp_valid` and `instr_ready` respond immediately.
  - Throughput is therefore at most one instruction per 3 cycles.
- **`pcsrc`, `pc_take`, `imm` and `rs1_data`** are sampled only in the cycle where `instr_valid` and `instr_ready` are both 1.

## Test plan
- **Reset and first fetch:** `RESET_PC`=32'h100, `req_ready` tied to 1, the memory returns 32'h00000013 one cycle later, `instr_ready`=1 → required response:
  - `req_addr` sequence is 0x100, 0x104, 0x108, with `req_valid` high 1 of every 3 cycles.
  - `retired`=3 after 9 cycles.
- **Taken branch:** at `instr_pc`=0x200, consume with `pcsrc`=01, `pc_take`=1, `imm`=32'hFFFF_FFF0 → next `req_addr`=0x1F0.
- **Not-taken branch:** the same stimulus with `pc_take`=0 → next `req_addr`=0x204.
- **`jalr`:** `pcsrc`=11, `rs1_data`=0x301, `imm`=4 → target 0x304 after bit 0 is cleared.
- **Misaligned `jalr`:** `rs1_data`=0x302, `imm`=0 → required response:
  - `misalign`=1.
  - FSM in `S_HALT` with no further `req_valid`.
  - `rst` is the only exit, and reset returns `req_addr` to `RESET_PC`.
- **Backpressure and stray response:**
  - `req_ready` held low for 5 cycles → `req_valid` and `req_addr` stay stable for those cycles.
  - `resp_valid` pulsed while in `S_REQ` → ignored.
  - `instr_ready` held low for 4 cycles → `instr` and `instr_pc` stay stable and `retired` does not change.
  - `rst` asserted in `S_WAIT`, followed by a late `resp_valid` → the late response is discarded and `instr_valid` stays 0.

Source files
------------

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_unit_if : instruction-memory, decode and next-PC signals of the fetch stage
// Revision      : 1.0
// ------------------------------------------------------------------
interface fetch_unit_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [1:0]  pcsrc;
  logic        pc_take;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        misalign;
  logic [31:0] retired;

  modport master (
    output req_valid, req_addr, instr_valid, instr, instr_pc, misalign, retired,
    input  req_ready, resp_valid, resp_data, instr_ready, pcsrc, pc_take, imm, rs1_data
  );

  modport slave (
    input  req_valid, req_addr, instr_valid, instr, instr_pc, misalign, retired,
    output req_ready, resp_valid, resp_data, instr_ready, pcsrc, pc_take, imm, rs1_data
  );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// fetch_unit : single-outstanding instruction fetch with next-PC resolution
// Revision   : 1.0
// ------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  wire          clk,
  input  wire          rst,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        misalign_q, misalign_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] next_pc;
  logic [31:0] jalr_sum;

  // Outputs decode registered state only, never the inputs.
  assign bus.req_valid   = (state_q == S_REQ);
  assign bus.req_addr    = pc_q;
  assign bus.instr_valid = (state_q == S_HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.misalign    = misalign_q;
  assign bus.retired     = retired_q;

  assign jalr_sum = bus.rs1_data + bus.imm;

  always_comb begin
    next_pc = pc_q + 32'd4;
    if (bus.pcsrc == 2'b01 && bus.pc_take) begin
      next_pc = pc_q + bus.imm;
    end else if (bus.pcsrc == 2'b11) begin
      next_pc = {jalr_sum[31:1], 1'b0};
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    misalign_d = misalign_q;
    retired_d  = retired_q;
    case (state_q)
      S_REQ: begin
        if (bus.req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.resp_valid) begin
          instr_d    = bus.resp_data;
          instr_pc_d = pc_q;
          state_d    = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.instr_ready) begin
          retired_d = retired_q + 32'd1;
          // A misaligned target halts with the PC left on the offending instruction.
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end else begin
            misalign_d = 1'b1;
            state_d    = S_HALT;
          end
        end
      end
      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      instr_q    <= 32'd0;
      instr_pc_q <= 32'd0;
      misalign_q <= 1'b0;
      retired_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      misalign_q <= misalign_d;
      retired_q  <= retired_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Revision      : 1.0
// ------------------------------------------------------------------
module tb_fetch_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC (32'h0000_0100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    bus.resp_data   = 32'd0;
    bus.instr_ready = 1'b0;
    bus.pcsrc       = 2'b00;
    bus.pc_take     = 1'b0;
    bus.imm         = 32'd0;
    bus.rs1_data    = 32'd0;
  endtask

  // From S_REQ: request accepted, response one cycle later, ends in S_HOLD.
  task automatic fetch_one(input logic [31:0] word);
    bus.req_ready = 1'b1;
    step();
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b1;
    bus.resp_data  = word;
    step();
    bus.resp_valid = 1'b0;
  endtask

  task automatic consume(input logic [1:0] src, input logic take,
                         input logic [31:0] im, input logic [31:0] rs1);
    bus.instr_ready = 1'b1;
    bus.pcsrc       = src;
    bus.pc_take     = take;
    bus.imm         = im;
    bus.rs1_data    = rs1;
    step();
    idle_inputs();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req_valid"},   {31'd0, bus.req_valid},   32'd1);
    chk({tag, "_req_addr"},    bus.req_addr,             32'h100);
    chk({tag, "_instr_valid"}, {31'd0, bus.instr_valid}, 32'd0);
    chk({tag, "_instr"},       bus.instr,                32'd0);
    chk({tag, "_instr_pc"},    bus.instr_pc,             32'd0);
    chk({tag, "_misalign"},    {31'd0, bus.misalign},    32'd0);
    chk({tag, "_retired"},     bus.retired,              32'd0);
  endtask

  initial begin
    logic prev_accept;
    checks = 0;
    errors = 0;
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    check_reset_state("reset");
    rst = 1'b0;

    // Free-running loop: 3 cycles per instruction.
    prev_accept = 1'b0;
    bus.req_ready   = 1'b1;
    bus.instr_ready = 1'b1;
    bus.resp_data   = 32'h0000_0013;
    for (int i = 0; i < 9; i++) begin
      chk("loop_req_valid", {31'd0, bus.req_valid}, {31'd0, (i % 3) == 0});
      if ((i % 3) == 0) chk("loop_req_addr", bus.req_addr, 32'h100 + 32'(4 * (i / 3)));
      if ((i % 3) == 2) begin
        chk("loop_instr", bus.instr, 32'h0000_0013);
        chk("loop_instr_pc", bus.instr_pc, 32'h100 + 32'(4 * (i / 3)));
      end
      bus.resp_valid = prev_accept;
      prev_accept = bus.req_valid & bus.req_ready;
      step();
    end
    idle_inputs();
    chk("loop_retired", bus.retired, 32'd3);
    chk("loop_next_addr", bus.req_addr, 32'h10C);

    // Backpressure on the request with a stray response in S_REQ.
    for (int i = 0; i < 5; i++) begin
      bus.resp_valid = (i == 2);
      bus.resp_data  = 32'hDEAD_BEEF;
      chk("bp_req_valid", {31'd0, bus.req_valid}, 32'd1);
      chk("bp_req_addr", bus.req_addr, 32'h10C);
      step();
    end
    bus.resp_valid = 1'b0;
    chk("stray_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("stray_instr", bus.instr, 32'h0000_0013);

    // Decode backpressure holds instr and retired.
    fetch_one(32'h0050_0093);
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid", {31'd0, bus.instr_valid}, 32'd1);
      chk("hold_instr", bus.instr, 32'h0050_0093);
      chk("hold_pc", bus.instr_pc, 32'h10C);
      chk("hold_retired", bus.retired, 32'd3);
      step();
    end
    consume(2'b11, 1'b0, 32'd0, 32'h200);
    chk("jump200_addr", bus.req_addr, 32'h200);
    chk("jump200_valid", {31'd0, bus.req_valid}, 32'd1);
    chk("jump200_retired", bus.retired, 32'd4);

    // Taken branch backward.
    fetch_one(32'h0000_0063);
    chk("br_instr_pc", bus.instr_pc, 32'h200);
    consume(2'b01, 1'b1, 32'hFFFF_FFF0, 32'd0);
    chk("taken_addr", bus.req_addr, 32'h1F0);

    // Return to 0x200, then not-taken branch.
    fetch_one(32'h0000_0067);
    consume(2'b11, 1'b0, 32'd0, 32'h200);
    fetch_one(32'h0000_0063);
    consume(2'b01, 1'b0, 32'hFFFF_FFF0, 32'd0);
    chk("not_taken_addr", bus.req_addr, 32'h204);

    // pcsrc=10 behaves as PC+4.
    fetch_one(32'h0000_0013);
    consume(2'b10, 1'b1, 32'h100, 32'h400);
    chk("src10_addr", bus.req_addr, 32'h208);

    // jalr clears bit 0 of the target.
    fetch_one(32'h0000_0067);
    consume(2'b11, 1'b0, 32'd4, 32'h301);
    chk("jalr_addr", bus.req_addr, 32'h304);
    chk("jalr_misalign", {31'd0, bus.misalign}, 32'd0);

    // Reset in S_WAIT, then a late response must be dropped.
    bus.req_ready = 1'b1;
    step();
    bus.req_ready = 1'b0;
    chk("wait_req_valid", {31'd0, bus.req_valid}, 32'd0);
    rst = 1'b1;
    bus.resp_valid = 1'b1;
    bus.resp_data  = 32'hBAD0_0000;
    step();
    rst = 1'b0;
    check_reset_state("wait_reset");
    step();
    bus.resp_valid = 1'b0;
    chk("late_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
    chk("late_instr", bus.instr, 32'd0);
    step();
    chk("late_instr_valid2", {31'd0, bus.instr_valid}, 32'd0);

    // Misaligned jalr halts.
    fetch_one(32'h0000_0067);
    consume(2'b11, 1'b0, 32'd0, 32'h302);
    chk("mis_flag", {31'd0, bus.misalign}, 32'd1);
    chk("mis_req_addr", bus.req_addr, 32'h100);
    chk("mis_retired", bus.retired, 32'd1);
    bus.req_ready   = 1'b1;
    bus.resp_valid  = 1'b1;
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("halt_req_valid", {31'd0, bus.req_valid}, 32'd0);
      chk("halt_instr_valid", {31'd0, bus.instr_valid}, 32'd0);
      chk("halt_misalign", {31'd0, bus.misalign}, 32'd1);
      step();
    end
    chk("halt_retired", bus.retired, 32'd1);
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("halt_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound so the bench can never hang.
  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
